// File: rtl/fft_addr_pkg.sv
// Shared types and address helpers for the radix-2 in-place FFT address sequencer.
// Address fields are sized to ADDR_MAX so one struct serves every AddrWidth build.
package fft_addr_pkg;

  localparam int unsigned ADDR_MAX = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic                ren;
    logic [ADDR_MAX-1:0] addr_a;
    logic [ADDR_MAX-1:0] addr_b;
  } wb_entry_t;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [ADDR_MAX-1:0] bitrev(input logic [ADDR_MAX-1:0] v,
                                                 input int unsigned w);
    logic [ADDR_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ADDR_MAX; i++) begin
      if (i < w) r = r | (ADDR_MAX'(v[i]) << (w - 1 - i));
    end
    return r;
  endfunction

  function automatic logic [ADDR_MAX-1:0] insert_zero(input logic [ADDR_MAX-1:0] k,
                                                      input int unsigned s);
    logic [ADDR_MAX-1:0] mask;
    mask = (ADDR_MAX'(1) << s) - ADDR_MAX'(1);
    return ((k & ~mask) << 1) | (k & mask);
  endfunction

endpackage

// File: rtl/fft_addr_gen_if.sv
// Control/address bundle between the FFT address sequencer and its surroundings.
interface fft_addr_gen_if #(
  parameter int unsigned AddrWidth = 7,
  parameter int unsigned StageW    = $clog2(AddrWidth + 1)
);
  logic                 start_i;
  logic                 in_valid_i;
  logic                 busy_o;
  logic                 done_o;
  logic [StageW-1:0]    stage_o;
  logic                 ren_o;
  logic [AddrWidth-1:0] rd_addr_a_o;
  logic [AddrWidth-1:0] rd_addr_b_o;
  logic [1:0]           wen_o;
  logic [AddrWidth-1:0] wr_addr_a_o;
  logic [AddrWidth-1:0] wr_addr_b_o;

  modport master (
    output start_i, in_valid_i,
    input  busy_o, done_o, stage_o, ren_o, rd_addr_a_o, rd_addr_b_o,
           wen_o, wr_addr_a_o, wr_addr_b_o
  );

  modport slave (
    input  start_i, in_valid_i,
    output busy_o, done_o, stage_o, ren_o, rd_addr_a_o, rd_addr_b_o,
           wen_o, wr_addr_a_o, wr_addr_b_o
  );
endinterface

// File: rtl/fft_addr_delay.sv
// Write-back delay line: carries each read pair to its butterfly write-back slot.
module fft_addr_delay
  import fft_addr_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  wb_entry_t i_entry,
  output wb_entry_t o_entry
);

  wb_entry_t r_line [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) r_line[i] <= '0;
    end else begin
      r_line[0] <= i_entry;
      for (int unsigned i = 1; i < Depth; i++) r_line[i] <= r_line[i-1];
    end
  end

  assign o_entry = r_line[Depth-1];

endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 in-place FFT address sequencer: LOAD, AddrWidth butterfly stages, DONE.
// Define FFT_ADDR_BITREV_EN to store samples at bit-reversed addresses during LOAD.
module fft_addr_gen
  import fft_addr_pkg::*;
#(
  parameter int unsigned AddrWidth = 7,
  parameter int unsigned BfLatency = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fft_addr_gen_if.slave bus
);

  localparam int unsigned KW     = AddrWidth - 1;
  localparam int unsigned StageW = $clog2(AddrWidth + 1);
  localparam int unsigned DW     = $clog2(BfLatency + 1);

  state_t               r_state, w_state;
  logic [AddrWidth-1:0] r_n, w_n;
  logic [KW-1:0]        r_k, w_k;
  logic [StageW-1:0]    r_s, w_s;
  logic [DW-1:0]        r_d, w_d;
  logic                 w_ld, w_done, w_ren;
  logic [AddrWidth-1:0] w_ld_addr, w_rd_a, w_rd_b;

  logic                 r_busy, r_done, r_ren, r_ld_wen;
  logic [StageW-1:0]    r_stage;
  logic [AddrWidth-1:0] r_rd_a, r_rd_b, r_ld_addr;

  wb_entry_t w_push, w_tail;
  logic      w_unused;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_k     <= '0;
      r_s     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state;
      r_n     <= w_n;
      r_k     <= w_k;
      r_s     <= w_s;
      r_d     <= w_d;
    end
  end

  always_comb begin
    w_state = r_state;
    w_n     = r_n;
    w_k     = r_k;
    w_s     = r_s;
    w_d     = r_d;
    w_ld    = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_state = LOAD;
          w_n     = '0;
        end
      end
      LOAD: begin
        if (bus.in_valid_i) begin
          w_ld = 1'b1;
          w_n  = r_n + AddrWidth'(1);
          if (r_n == '1) begin
            w_state = COMPUTE;
            w_s     = '0;
            w_k     = '0;
          end
        end
      end
      COMPUTE: begin
        if (r_k == '1) begin
          w_state = DRAIN;
          w_d     = '0;
        end else begin
          w_k = r_k + KW'(1);
        end
      end
      DRAIN: begin
        if (r_d == DW'(BfLatency - 1)) begin
          if (r_s == StageW'(AddrWidth - 1)) begin
            w_state = IDLE;
            w_done  = 1'b1;
            w_s     = '0;
          end else begin
            w_state = COMPUTE;
            w_s     = r_s + StageW'(1);
            w_k     = '0;
          end
        end else begin
          w_d = r_d + DW'(1);
        end
      end
      default: w_state = IDLE;
    endcase

    // Outputs are decoded from the next-state values so they register in step with the FSM.
    w_ren  = (w_state == COMPUTE);
    w_rd_a = '0;
    w_rd_b = '0;
    if (w_ren) begin
      w_rd_a = AddrWidth'(insert_zero(ADDR_MAX'(w_k), 32'(w_s)));
      w_rd_b = w_rd_a | (AddrWidth'(1) << w_s);
    end
`ifdef FFT_ADDR_BITREV_EN
    w_ld_addr = w_ld ? AddrWidth'(bitrev(ADDR_MAX'(r_n), AddrWidth)) : '0;
`else
    w_ld_addr = w_ld ? r_n : '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stage   <= '0;
      r_ren     <= 1'b0;
      r_rd_a    <= '0;
      r_rd_b    <= '0;
      r_ld_wen  <= 1'b0;
      r_ld_addr <= '0;
    end else begin
      r_busy    <= (w_state != IDLE);
      r_done    <= w_done;
      r_stage   <= (w_state == COMPUTE || w_state == DRAIN) ? w_s : '0;
      r_ren     <= w_ren;
      r_rd_a    <= w_rd_a;
      r_rd_b    <= w_rd_b;
      r_ld_wen  <= w_ld;
      r_ld_addr <= w_ld_addr;
    end
  end

  always_comb begin
    w_push        = '0;
    w_push.ren    = r_ren;
    w_push.addr_a = ADDR_MAX'(r_rd_a);
    w_push.addr_b = ADDR_MAX'(r_rd_b);
  end

  fft_addr_delay #(
    .Depth (BfLatency)
  ) u_delay (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_entry (w_push),
    .o_entry (w_tail)
  );

  assign w_unused = ^{w_tail.addr_a >> AddrWidth, w_tail.addr_b >> AddrWidth};

  // Load writes and write-backs never overlap, and idle fields are zero, so OR-merging is safe.
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.stage_o     = r_stage;
  assign bus.ren_o       = r_ren;
  assign bus.rd_addr_a_o = r_rd_a;
  assign bus.rd_addr_b_o = r_rd_b;
  assign bus.wen_o       = {w_tail.ren, w_tail.ren | r_ld_wen};
  assign bus.wr_addr_a_o = AddrWidth'(w_tail.addr_a) | r_ld_addr;
  assign bus.wr_addr_b_o = AddrWidth'(w_tail.addr_b);

endmodule
